// File: rtl/pipeline_muldiv_if.sv
// Request/result bundle between the ALU stage (master) and the
// multiply/divide back end (slave).
interface pipeline_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic             op_ready;
    logic [5:0]       op;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] a1;
    logic             flush;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output op_valid, op, a0, a1, flush,
        input  op_ready, hi, lo, busy, done, div_by_zero
    );

    modport slave (
        input  op_valid, op, a0, a1, flush,
        output op_ready, hi, lo, busy, done, div_by_zero
    );
endinterface

// File: rtl/pipeline_muldiv.sv
// Multi-cycle multiply/divide unit owning HI/LO (radix-2^STEP_BITS shift-add
// multiply, restoring divide). Define MULDIV_DIV_EN to build in the divider.
module pipeline_muldiv #(
    parameter int WIDTH     = 32,
    parameter int STEP_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    pipeline_muldiv_if.slave bus
);
    localparam int K  = WIDTH / STEP_BITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = WIDTH + STEP_BITS;

    localparam logic [5:0] OP_MULT  = 6'b000100;
    localparam logic [5:0] OP_MTHI  = 6'b000101;
    localparam logic [5:0] OP_MTLO  = 6'b000110;
    localparam logic [5:0] OP_MULTU = 6'b000111;
`ifdef MULDIV_DIV_EN
    localparam logic [5:0] OP_DIV   = 6'b001000;
    localparam logic [5:0] OP_DIVU  = 6'b001001;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef MULDIV_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_FIX  = 2'd3
    } state_e;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        logic [WIDTH-1:0] m;
        if (is_signed && v[WIDTH-1]) begin
            m = {WIDTH{1'b0}} - v;
        end else begin
            m = v;
        end
        return m;
    endfunction

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               mul_q, mul_d;
    logic               neg_hi_q, neg_hi_d;
    logic               neg_lo_q, neg_lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               op_ready_s;
    logic               accept_s;
    logic               op_signed_s;
    logic [PW-1:0]      pp_s;
    logic [PW-1:0]      upper_s;
    logic [2*WIDTH-1:0] full_neg_s;
`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]     sh_s;
    logic [WIDTH:0]     diff_s;
`endif

    assign op_ready_s      = (state_q == S_IDLE) && !bus.flush && !rst;
    assign accept_s        = bus.op_valid && op_ready_s;
    assign bus.op_ready    = op_ready_s;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
`ifdef MULDIV_DIV_EN
    assign op_signed_s     = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign bus.div_by_zero = dbz_q;
`else
    assign op_signed_s     = (bus.op == OP_MULT);
    assign bus.div_by_zero = 1'b0;
`endif

    // Next-state and datapath: one multiply digit or one quotient bit per cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        opb_d    = opb_q;
        mul_d    = mul_q;
        neg_hi_d = neg_hi_q;
        neg_lo_d = neg_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;

        pp_s       = {{STEP_BITS{1'b0}}, opb_q} * {{WIDTH{1'b0}}, prod_q[STEP_BITS-1:0]};
        upper_s    = {{STEP_BITS{1'b0}}, prod_q[2*WIDTH-1:WIDTH]} + pp_s;
        full_neg_s = {(2*WIDTH){1'b0}} - prod_q;
`ifdef MULDIV_DIV_EN
        sh_s       = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        diff_s     = sh_s - {1'b0, opb_q};
`endif

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    case (bus.op)
                        OP_MTHI: begin
                            hi_d   = bus.a0;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = bus.a0;
                            done_d = 1'b1;
                        end
                        OP_MULT, OP_MULTU: begin
                            prod_d   = {{WIDTH{1'b0}}, magnitude(bus.a1, op_signed_s)};
                            opb_d    = magnitude(bus.a0, op_signed_s);
                            mul_d    = 1'b1;
                            neg_lo_d = op_signed_s && (bus.a0[WIDTH-1] ^ bus.a1[WIDTH-1]);
                            neg_hi_d = op_signed_s && (bus.a0[WIDTH-1] ^ bus.a1[WIDTH-1]);
                            cnt_d    = CW'(K - 1);
                            state_d  = S_MUL;
                        end
`ifdef MULDIV_DIV_EN
                        OP_DIV, OP_DIVU: begin
                            if (bus.a1 == {WIDTH{1'b0}}) begin
                                hi_d   = bus.a0;
                                lo_d   = {WIDTH{1'b1}};
                                done_d = 1'b1;
                                dbz_d  = 1'b1;
                            end else begin
                                prod_d   = {{WIDTH{1'b0}}, magnitude(bus.a0, op_signed_s)};
                                opb_d    = magnitude(bus.a1, op_signed_s);
                                mul_d    = 1'b0;
                                // quotient sign from both operands, remainder follows dividend
                                neg_lo_d = op_signed_s && (bus.a0[WIDTH-1] ^ bus.a1[WIDTH-1]);
                                neg_hi_d = op_signed_s && bus.a0[WIDTH-1];
                                cnt_d    = CW'(WIDTH - 1);
                                state_d  = S_DIV;
                            end
                        end
`endif
                        default: begin
                            done_d = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    prod_d = {upper_s, prod_q[WIDTH-1:STEP_BITS]};
                    if (cnt_q == {CW{1'b0}}) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
`ifdef MULDIV_DIV_EN
            S_DIV: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (!diff_s[WIDTH]) begin
                        prod_d = {diff_s[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
                    end else begin
                        prod_d = {sh_s[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
                    end
                    if (cnt_q == {CW{1'b0}}) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
`endif
            S_FIX: begin
                state_d = S_IDLE;
                if (bus.flush) begin
                    done_d = 1'b0;
                end else if (mul_q) begin
                    hi_d   = neg_lo_q ? full_neg_s[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
                    lo_d   = neg_lo_q ? full_neg_s[WIDTH-1:0] : prod_q[WIDTH-1:0];
                    done_d = 1'b1;
                end else begin
                    hi_d   = neg_hi_q ? ({WIDTH{1'b0}} - prod_q[2*WIDTH-1:WIDTH])
                                      : prod_q[2*WIDTH-1:WIDTH];
                    lo_d   = neg_lo_q ? ({WIDTH{1'b0}} - prod_q[WIDTH-1:0])
                                      : prod_q[WIDTH-1:0];
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CW{1'b0}};
            prod_q   <= {(2*WIDTH){1'b0}};
            opb_q    <= {WIDTH{1'b0}};
            mul_q    <= 1'b0;
            neg_hi_q <= 1'b0;
            neg_lo_q <= 1'b0;
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            opb_q    <= opb_d;
            mul_q    <= mul_d;
            neg_hi_q <= neg_hi_d;
            neg_lo_q <= neg_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end
endmodule

// File: tb/tb_pipeline_muldiv.sv
// Directed bench for pipeline_muldiv (WIDTH=32, STEP_BITS=2); expectations
// follow MULDIV_DIV_EN so the same bench covers both builds.
module tb_pipeline_muldiv;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipeline_muldiv_if #(.WIDTH(32)) bus ();

    pipeline_muldiv #(.WIDTH(32), .STEP_BITS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [5:0] OP_MULT  = 6'b000100;
    localparam logic [5:0] OP_MTHI  = 6'b000101;
    localparam logic [5:0] OP_MTLO  = 6'b000110;
    localparam logic [5:0] OP_MULTU = 6'b000111;
    localparam logic [5:0] OP_DIV   = 6'b001000;
    localparam logic [5:0] OP_DIVU  = 6'b001001;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op at the next edge and wait (bounded) for done; called at negedge.
    task automatic run_op(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output bit stable, output bit busy_first,
                          output bit dbz_done, output bit busy_done);
        logic [31:0] h0;
        logic [31:0] l0;
        h0 = bus.hi;
        l0 = bus.lo;
        stable = 1'b1;
        lat = 0;
        bus.op_valid = 1'b1;
        bus.op = o;
        bus.a0 = x;
        bus.a1 = y;
        @(posedge clk);
        @(negedge clk);
        bus.op_valid = 1'b0;
        busy_first = bus.busy;
        while (!bus.done && lat < 100) begin
            if (bus.hi !== h0 || bus.lo !== l0) stable = 1'b0;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        dbz_done = bus.div_by_zero;
        busy_done = bus.busy;
    endtask

    int          lat;
    bit          stable, busy_first, dbz_done, busy_done;
    logic [31:0] exp_hi, exp_lo;

    initial begin
        rst = 1'b1;
        bus.op_valid = 1'b0;
        bus.op = 6'd0;
        bus.a0 = 32'd0;
        bus.a1 = 32'd0;
        bus.flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ready_in_rst", {63'd0, bus.op_ready}, 64'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", {63'd0, bus.op_ready}, 64'd1);
        check("rst_hi", {32'd0, bus.hi}, 64'd0);
        check("rst_lo", {32'd0, bus.lo}, 64'd0);
        check("rst_flags", {61'd0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);

        // mthi then mtlo on consecutive cycles
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op = OP_MTHI;
        bus.a0 = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        check("mthi_done", {63'd0, bus.done}, 64'd1);
        check("mthi_hilo", {bus.hi, bus.lo}, {32'h12345678, 32'h0});
        check("mthi_ready", {63'd0, bus.op_ready}, 64'd1);
        bus.op = OP_MTLO;
        bus.a0 = 32'h9ABCDEF0;
        @(posedge clk);
        @(negedge clk);
        bus.op_valid = 1'b0;
        check("mtlo_done", {63'd0, bus.done}, 64'd1);
        check("mtlo_hilo", {bus.hi, bus.lo}, {32'h12345678, 32'h9ABCDEF0});

        run_op(OP_MULT, 32'hFFFFFFFF, 32'h00000002, lat, stable, busy_first, dbz_done, busy_done);
        check("mult_lat", 64'(lat), 64'd17);
        check("mult_stable", {63'd0, stable}, 64'd1);
        check("mult_busy", {62'd0, busy_first, busy_done}, 64'd2);
        check("mult_res", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFE);

        run_op(OP_MULTU, 32'hFFFFFFFF, 32'h00000002, lat, stable, busy_first, dbz_done, busy_done);
        check("multu_lat", 64'(lat), 64'd17);
        check("multu_res", {bus.hi, bus.lo}, 64'h00000001_FFFFFFFE);

        run_op(OP_MULT, 32'd3, 32'hFFFFFFFB, lat, stable, busy_first, dbz_done, busy_done);
        check("mult_neg_res", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFF1);

        run_op(OP_MULTU, 32'h00010000, 32'h00010000, lat, stable, busy_first, dbz_done, busy_done);
        check("multu_2p32", {bus.hi, bus.lo}, 64'h00000001_00000000);

        exp_hi = bus.hi;
        exp_lo = bus.lo;
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, lat, stable, busy_first, dbz_done, busy_done);
`ifdef MULDIV_DIV_EN
        check("div_lat", 64'(lat), 64'd33);
        check("div_stable", {63'd0, stable}, 64'd1);
        check("div_res", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, stable, busy_first, dbz_done, busy_done);
        check("div_min", {bus.hi, bus.lo}, 64'h00000000_80000000);
        run_op(OP_DIVU, 32'd5, 32'd0, lat, stable, busy_first, dbz_done, busy_done);
        check("dbz_lat", 64'(lat), 64'd0);
        check("dbz_flags", {61'd0, dbz_done, busy_first, busy_done}, 64'd4);
        check("dbz_res", {bus.hi, bus.lo}, 64'h00000005_FFFFFFFF);
        exp_hi = 32'h00000005;
        exp_lo = 32'hFFFFFFFF;
`else
        check("div_nop_lat", 64'(lat), 64'd0);
        check("div_nop_res", {bus.hi, bus.lo}, {exp_hi, exp_lo});
        run_op(OP_DIVU, 32'd5, 32'd0, lat, stable, busy_first, dbz_done, busy_done);
        check("divu_nop_flags", {61'd0, dbz_done, busy_first, busy_done}, 64'd0);
        check("divu_nop_res", {bus.hi, bus.lo}, {exp_hi, exp_lo});
`endif
        check("dbz_ready", {63'd0, bus.op_ready}, 64'd1);

        run_op(6'h3F, 32'hAAAAAAAA, 32'h55555555, lat, stable, busy_first, dbz_done, busy_done);
        check("nop_lat", 64'(lat), 64'd0);
        check("nop_res", {bus.hi, bus.lo}, {exp_hi, exp_lo});

        // Flush a mult in flight while an mthi request is held
        bus.op_valid = 1'b1;
        bus.op = OP_MULT;
        bus.a0 = 32'd7;
        bus.a1 = 32'd9;
        @(posedge clk);
        @(negedge clk);
        bus.op = OP_MTHI;
        bus.a0 = 32'hCAFEF00D;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("held_not_taken", {bus.hi, bus.lo}, {exp_hi, exp_lo});
        check("busy_ready", {62'd0, bus.busy, bus.op_ready}, 64'd2);
        bus.flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        check("flush_state", {61'd0, bus.busy, bus.done, bus.op_ready}, 64'd1);
        check("flush_hilo", {bus.hi, bus.lo}, {exp_hi, exp_lo});
        @(posedge clk);
        @(negedge clk);
        bus.op_valid = 1'b0;
        check("held_taken", {31'd0, bus.done, bus.hi}, {31'd0, 1'b1, 32'hCAFEF00D});

        // Reset in the middle of a long op
        bus.op_valid = 1'b1;
`ifdef MULDIV_DIV_EN
        bus.op = OP_DIVU;
`else
        bus.op = OP_MULTU;
`endif
        bus.a0 = 32'd100;
        bus.a1 = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.op_valid = 1'b0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("rst_mid_ready", {63'd0, bus.op_ready}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
        check("rst_mid_flags", {61'd0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);
        rst = 1'b0;
        lat = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done || bus.busy) lat++;
        end
        check("rst_mid_quiet", 64'(lat), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
